// File: rtl/register_pkg.sv
// Shared definitions for the primary/shadow register sequencer.
package register_pkg;

    // Number of register pairs handled (bit 0 = A, 1 = B, 2 = C).
    localparam int NREG  = 3;
    // Width of the writeback target select; codes >= NREG are invalid.
    localparam int SEL_W = 2;

    // Register index constants.
    localparam int REG_A = 0;
    localparam int REG_B = 1;
    localparam int REG_C = 2;

    // Sequencer state encoding.
    typedef enum logic {
        IDLE = 1'b0,
        EXCH = 1'b1
    } state_e;

endpackage : register_pkg

// File: rtl/register_ctrl_if.sv
// Request/strobe bundle between decode, the sequencer and the register pairs.
interface register_ctrl_if;
    import register_pkg::*;

    logic             WrReq;
    logic [SEL_W-1:0] WrSel;
    logic             WrReady;
    logic             ExReq;
    logic [NREG-1:0]  ExMask;
    logic             ExReady;
    logic             ExDone;
    logic [NREG-1:0]  PR_Write;
    logic [NREG-1:0]  PR_Ex;
    logic [NREG-1:0]  notPR_Ex;
    logic [NREG-1:0]  SH_Load;
    logic             Busy;

    // Decode side: issues requests, observes handshakes and strobes.
    modport master (
        output WrReq, WrSel, ExReq, ExMask,
        input  WrReady, ExReady, ExDone, PR_Write, PR_Ex, notPR_Ex, SH_Load, Busy
    );

    // Sequencer side.
    modport slave (
        input  WrReq, WrSel, ExReq, ExMask,
        output WrReady, ExReady, ExDone, PR_Write, PR_Ex, notPR_Ex, SH_Load, Busy
    );

endinterface : register_ctrl_if

// File: rtl/register_ctrl_prio.sv
// Lowest-set-bit one-hot picker over the pending exchange mask.
module register_ctrl_prio
    import register_pkg::*;
(
    input  logic [NREG-1:0] mask_i,
    output logic [NREG-1:0] onehot_o,
    output logic            last_o
);

    // Isolate the lowest set bit; flag when it is the only bit left.
    always_comb begin
        onehot_o = mask_i & (~mask_i + NREG'(1));
        last_o   = (mask_i != '0) && ((mask_i & ~onehot_o) == '0);
    end

endmodule : register_ctrl_prio

// File: rtl/register_ctrl.sv
// Sequencer turning writeback/exchange requests into registered per-register
// write, exchange and shadow-capture strobes. Writeback wins over exchange;
// multi-register exchanges are walked lowest bit first, one per cycle.
module register_ctrl
    import register_pkg::*;
(
    input  logic           Clk,
    input  logic           notClk,
    input  logic           notReset,
    register_ctrl_if.slave bus
);

    // notClk is distributed with the clock tree but no state runs on it.
    wire unused_notclk = notClk;

    state_e          state_q, state_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic [NREG-1:0] pr_write_q, pr_write_d;
    logic [NREG-1:0] pr_ex_q, pr_ex_d;
    logic [NREG-1:0] npr_ex_q;
    logic            exdone_q, exdone_d;

    logic            wr_ready, ex_ready;
    logic            wr_acc, ex_acc;
    logic [NREG-1:0] pick_mask, pick_oh;
    logic            pick_last;

    // Handshake readies from state; held low while reset is asserted.
    always_comb begin
        wr_ready = 1'b0;
        ex_ready = 1'b0;
        if (notReset && (state_q == IDLE)) begin
            wr_ready = 1'b1;
            ex_ready = ~bus.WrReq;
        end
    end

    assign wr_acc = bus.WrReq & wr_ready;
    assign ex_acc = bus.ExReq & ex_ready;

    // In IDLE the picker looks at the incoming mask so the first strobe is
    // registered on the accepting edge; in EXCH it walks the pending bits.
    assign pick_mask = (state_q == EXCH) ? pend_q : bus.ExMask;

    register_ctrl_prio u_prio (
        .mask_i   (pick_mask),
        .onehot_o (pick_oh),
        .last_o   (pick_last)
    );

    // Next-state and next-strobe decode.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pr_write_d = '0;
        pr_ex_d    = '0;
        exdone_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_acc) begin
                    if (bus.WrSel < SEL_W'(NREG))
                        pr_write_d = NREG'(1) << bus.WrSel;
                end else if (ex_acc) begin
                    if (bus.ExMask == '0) begin
                        exdone_d = 1'b1;
                    end else begin
                        state_d  = EXCH;
                        pr_ex_d  = pick_oh;
                        pend_d   = bus.ExMask & ~pick_oh;
                        exdone_d = pick_last;
                    end
                end
            end
            EXCH: begin
                // Empty pending mask means the final strobe is on the outputs now.
                if (pend_q == '0) begin
                    state_d = IDLE;
                end else begin
                    pr_ex_d  = pick_oh;
                    pend_d   = pend_q & ~pick_oh;
                    exdone_d = pick_last;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pending mask and glitch-free strobe flops.
    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            pr_write_q <= '0;
            pr_ex_q    <= '0;
            npr_ex_q   <= '1;
            exdone_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pr_write_q <= pr_write_d;
            pr_ex_q    <= pr_ex_d;
            npr_ex_q   <= ~pr_ex_d;
            exdone_q   <= exdone_d;
        end
    end

    assign bus.WrReady  = wr_ready;
    assign bus.ExReady  = ex_ready;
    assign bus.ExDone   = exdone_q;
    assign bus.PR_Write = pr_write_q;
    assign bus.PR_Ex    = pr_ex_q;
    assign bus.notPR_Ex = npr_ex_q;
    assign bus.SH_Load  = pr_ex_q;
    assign bus.Busy     = (state_q == EXCH);

endmodule : register_ctrl
